data_memory_be: RTL and testbench

- Parametrised successor to the single-cycle MIPS data memory.
- Byte-addressed, with byte/half/word loads and stores, and sign/zero extension on loads.
- Detects misaligned accesses.
- After reset, a sequential clear engine zeroes the array one word per clock, so the array needs no async reset.
- Sits in the MEM stage: ALU result drives A, rt drives WD, RD feeds the writeback mux.

---
 rtl/data_memory_be.sv | 152 +++++++++++++++
 tb/tb_data_memory_be.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/data_memory_be.sv
// Byte-addressed little-endian data memory with byte/half/word access, load extension,
// misalign detection and a post-reset clear engine. Define DMEM_TEST_PORT_EN for test_value.
module data_memory_be #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [31:0] CLR_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic        RE,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        busy,
  output logic        misalign,
  output logic        err_sticky,
  input  logic        err_clr
`ifdef DMEM_TEST_PORT_EN
  ,
  output logic [15:0] test_value
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                err_q, err_d;

  logic [31:0]         mem_q [DEPTH];

  logic [ADDR_W-1:0]   widx;
  logic [1:0]          lane;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         wr_data;
  logic [3:0]          wr_be;
  logic                st_en;
  logic                clr_en;
  logic                unused_a_hi;

  // Upper address bits alias; only the word index and lane are decoded.
  assign widx        = A[ADDR_W+1:2];
  assign lane        = A[1:0];
  assign unused_a_hi = ^A[31:ADDR_W+2];

  assign busy       = (state_q == CLEAR);
  assign err_sticky = err_q;

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = A[0];
      2'b10:   misalign = |A[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // State, clear index and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    err_d     = err_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = ADDR_W'(clr_idx_q + 1'b1);
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
    // A new error in the same cycle as err_clr takes priority.
    if (err_clr) err_d = 1'b0;
    if ((WE | RE) & misalign & ~busy) err_d = 1'b1;
  end

  // Store lane replication and byte enables.
  always_comb begin
    wr_data = WD;
    wr_be   = 4'b0000;
    case (size)
      2'b00: begin
        wr_data = {4{WD[7:0]}};
        wr_be   = 4'(4'b0001 << lane);
      end
      2'b01: begin
        wr_data = {2{WD[15:0]}};
        wr_be   = A[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        wr_data = WD;
        wr_be   = 4'b1111;
      end
      default: wr_be = 4'b0000;
    endcase
  end

  assign st_en  = WE & ~busy & ~misalign;
  assign clr_en = busy & reset;

  // Array has no reset; the clear engine initialises it.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_idx_q] <= CLR_VAL;
    end else if (st_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[widx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_word = mem_q[widx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = A[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    RD = 32'h0;
    if (!(misalign | busy)) begin
      case (size)
        2'b00:   RD = unsigned_ld ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        2'b01:   RD = unsigned_ld ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        2'b10:   RD = rd_word;
        default: RD = 32'h0;
      endcase
    end
  end

`ifdef DMEM_TEST_PORT_EN
  logic [31:0] word0;
  assign word0      = mem_q[0];
  assign test_value = busy ? 16'h0 : word0[15:0];
`endif

endmodule

// File: tb/tb_data_memory_be.sv
// Directed self-checking bench for data_memory_be (default ADDR_W=8, CLR_VAL=0).
module tb_data_memory_be;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE, RE, unsigned_ld, err_clr;
  logic [1:0]  size;
  logic [31:0] A, WD, RD;
  logic        busy, misalign, err_sticky;
`ifdef DMEM_TEST_PORT_EN
  logic [15:0] test_value;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  data_memory_be dut (
    .clk        (clk),
    .reset      (reset),
    .WE         (WE),
    .RE         (RE),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .A          (A),
    .WD         (WD),
    .RD         (RD),
    .busy       (busy),
    .misalign   (misalign),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
`ifdef DMEM_TEST_PORT_EN
    ,
    .test_value (test_value)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    A = a; WD = d; size = sz; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] exp);
    A = a; size = sz; unsigned_ld = uns; RE = 1'b1;
    #1;
    check_eq(tag, RD, exp);
    RE = 1'b0;
  endtask

  // Counts edges until busy drops, bounded so a stuck engine still reaches the summary.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; WE = 1'b0; RE = 1'b0; unsigned_ld = 1'b0; err_clr = 1'b0;
    size = 2'b10; A = '0; WD = '0;

    repeat (3) tick();
    check_eq("reset_busy", 32'(busy), 32'd1);
    check_eq("reset_err", 32'(err_sticky), 32'd0);
    reset = 1'b1;
    count_busy(n);
    check_eq("clear_cycles", 32'(n), 32'd256);
    check_eq("ready_busy", 32'(busy), 32'd0);
    do_load("lw_0x000", 32'h000, 2'b10, 1'b0, 32'h0);
    do_load("lw_0x3fc", 32'h3FC, 2'b10, 1'b0, 32'h0);

    do_store(32'h10, 32'h1122_3344, 2'b10);
    do_store(32'h12, 32'hFFFF_FFAA, 2'b00);
    do_load("lw_0x10", 32'h10, 2'b10, 1'b0, 32'h11AA_3344);
    do_load("lb_0x12", 32'h12, 2'b00, 1'b0, 32'hFFFF_FFAA);
    do_load("lbu_0x12", 32'h12, 2'b00, 1'b1, 32'h0000_00AA);
    do_load("lb_0x13", 32'h13, 2'b00, 1'b0, 32'h0000_0011);

    do_store(32'h22, 32'h0000_8001, 2'b01);
    do_load("lh_0x22", 32'h22, 2'b01, 1'b0, 32'hFFFF_8001);
    do_load("lhu_0x22", 32'h22, 2'b01, 1'b1, 32'h0000_8001);
    do_load("lw_0x20", 32'h20, 2'b10, 1'b0, 32'h8001_0000);

    // Misaligned word store: dropped, flags error.
    A = 32'h31; WD = 32'hDEAD_BEEF; size = 2'b10; WE = 1'b1;
    #1;
    check_eq("misalign_sw", 32'(misalign), 32'd1);
    check_eq("misalign_rd", RD, 32'h0);
    tick();
    WE = 1'b0;
    check_eq("err_set", 32'(err_sticky), 32'd1);
    do_load("lw_0x30", 32'h30, 2'b10, 1'b0, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("err_clr", 32'(err_sticky), 32'd0);

    A = 32'h40; size = 2'b11;
    #1;
    check_eq("misalign_sz11", 32'(misalign), 32'd1);
    A = 32'h21; size = 2'b01;
    #1;
    check_eq("misalign_half", 32'(misalign), 32'd1);
    // Set and clear in the same cycle: set wins.
    RE = 1'b1; err_clr = 1'b1;
    tick();
    RE = 1'b0; err_clr = 1'b0;
    check_eq("err_set_wins", 32'(err_sticky), 32'd1);

    do_store(32'h404, 32'h5A5A_5A5A, 2'b10);
    do_load("lw_alias", 32'h004, 2'b10, 1'b0, 32'h5A5A_5A5A);

    // Mid-clear reset, then a store while busy to an already-cleared word.
    do_store(32'h40, 32'h1234_5678, 2'b10);
    do_load("lw_0x40_pre", 32'h40, 2'b10, 1'b0, 32'h1234_5678);
    reset = 1'b0;
    tick();
    check_eq("reset_clears_err", 32'(err_sticky), 32'd0);
    reset = 1'b1;
    repeat (100) tick();
    reset = 1'b0;
    #1;
    check_eq("midclear_busy", 32'(busy), 32'd1);
    tick();
    reset = 1'b1;
    repeat (150) tick();
    do_store(32'h08, 32'hFFFF_FFFF, 2'b10);
    count_busy(n);
    check_eq("reclear_cycles", 32'(n + 151), 32'd256);
    do_load("lw_0x40_post", 32'h40, 2'b10, 1'b0, 32'h0);
    do_load("lw_busy_store", 32'h08, 2'b10, 1'b0, 32'h0);
    do_load("lw_alias_gone", 32'h004, 2'b10, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
